// File: rtl/glyph_row_fetcher_if.sv
// Glyph row fetcher bus: request handshake, glyph ROM mux port and pixel stream.
// slave = fetcher side, master = requester / ROM / pixel sink side.
interface glyph_row_fetcher_if;
    logic        req_valid;
    logic [3:0]  req_digit;
    logic        req_ready;
    logic [3:0]  mem_digit;
    logic [5:0]  mem_index_y;
    logic [63:0] mem_spo;
    logic        pix_valid;
    logic        pix_ready;
    logic        pix_data;
    logic [5:0]  pix_x;
    logic [5:0]  pix_y;
    logic        pix_last;
    logic        done;

    modport slave (
        input  req_valid, req_digit, mem_spo, pix_ready,
        output req_ready, mem_digit, mem_index_y,
               pix_valid, pix_data, pix_x, pix_y, pix_last, done
    );

    modport master (
        output req_valid, req_digit, mem_spo, pix_ready,
        input  req_ready, mem_digit, mem_index_y,
               pix_valid, pix_data, pix_x, pix_y, pix_last, done
    );
endinterface

// File: rtl/glyph_row_fetcher.sv
// Glyph row fetcher: reads a 64x64 digit glyph one row at a time from a
// combinational ROM mux and streams it out as 4096 single-pixel beats,
// rows 0..63, MSB of each row first.
// Optional feature macro: BLANK_ROW_SKIP_EN -- all-zero rows emit no beats.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  S_IDLE  | waiting for a request; req_ready high (except in done cycle)
//  S_ADDR  | row address on mem_index_y for one cycle of ROM settle
//  S_LOAD  | capture mem_spo into the shift register, clear column
//  S_SHIFT | emit one pixel per accepted beat, MSB first
//  S_NEXT  | end of row: finish glyph or advance to the next row
module glyph_row_fetcher (
    input  logic                i_clk,
    input  logic                i_reset,
    glyph_row_fetcher_if.slave  bus
);
    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_LOAD, S_SHIFT, S_NEXT} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_digit;
    logic [5:0]  r_row;
    logic [5:0]  r_col;
    logic [63:0] r_shift;
    logic        r_done;
    logic        w_ready;
    logic        w_accept;
    logic        w_beat;
    logic        w_row_blank;
    logic        w_last_row;
    logic [5:0]  w_index_y;

    // Ready is held low during the done pulse so a request raised alongside
    // done is taken no earlier than the following cycle.
    assign w_ready  = (r_state == S_IDLE) && !r_done;
    assign w_accept = bus.req_valid && w_ready;
    assign w_beat   = (r_state == S_SHIFT) && bus.pix_ready;

`ifdef BLANK_ROW_SKIP_EN
    // While a row is shifting out, the ROM port is free, so it scans the
    // remaining rows to learn whether any of them will emit beats. That
    // tells us in time whether the current row carries the final beat.
    // A row takes at least 64 SHIFT cycles and at most 63 rows remain.
    logic [6:0] r_scan;
    logic       r_tail_nz;

    assign w_row_blank = (bus.mem_spo == 64'd0);
    assign w_last_row  = !r_tail_nz;
    assign w_index_y   = (r_state == S_SHIFT) ? r_scan[5:0] : r_row;

    // Look-ahead scan of rows below the current one
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_scan    <= 7'd64;
            r_tail_nz <= 1'b0;
        end else if (r_state == S_LOAD) begin
            r_scan    <= {1'b0, r_row} + 7'd1;
            r_tail_nz <= 1'b0;
        end else if (r_state == S_SHIFT && !r_scan[6]) begin
            r_scan    <= r_scan + 7'd1;
            r_tail_nz <= r_tail_nz | (bus.mem_spo != 64'd0);
        end
    end
`else
    assign w_row_blank = 1'b0;
    assign w_last_row  = (r_row == 6'd63);
    assign w_index_y   = r_row;
`endif

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_ADDR;
            S_ADDR:  w_next = S_LOAD;
            S_LOAD:  w_next = w_row_blank ? S_NEXT : S_SHIFT;
            S_SHIFT: if (w_beat && r_col == 6'd63) w_next = S_NEXT;
            S_NEXT:  w_next = (r_row == 6'd63) ? S_IDLE : S_ADDR;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: digit latch, row/column counters, row shift register, done
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_digit <= 4'd0;
            r_row   <= 6'd0;
            r_col   <= 6'd0;
            r_shift <= 64'd0;
            r_done  <= 1'b0;
        end else begin
            r_done <= (r_state == S_NEXT) && (r_row == 6'd63);
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_digit <= bus.req_digit;
                        r_row   <= 6'd0;
                    end
                end
                S_LOAD: begin
                    r_shift <= bus.mem_spo;
                    r_col   <= 6'd0;
                end
                S_SHIFT: begin
                    if (bus.pix_ready) begin
                        r_shift <= {r_shift[62:0], 1'b0};
                        r_col   <= r_col + 6'd1;
                    end
                end
                S_NEXT: begin
                    if (r_row != 6'd63) r_row <= r_row + 6'd1;
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from state and registers; pixel fields are zero outside SHIFT
    always_comb begin
        bus.req_ready   = w_ready;
        bus.mem_digit   = r_digit;
        bus.mem_index_y = w_index_y;
        bus.pix_valid   = (r_state == S_SHIFT);
        bus.pix_data    = (r_state == S_SHIFT) && r_shift[63];
        bus.pix_x       = (r_state == S_SHIFT) ? r_col : 6'd0;
        bus.pix_y       = (r_state == S_SHIFT) ? r_row : 6'd0;
        bus.pix_last    = (r_state == S_SHIFT) && (r_col == 6'd63) && w_last_row;
        bus.done        = r_done;
    end
endmodule

// File: tb/tb_glyph_row_fetcher.sv
// Directed bench for glyph_row_fetcher with a behavioural glyph ROM.
module tb_glyph_row_fetcher;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    glyph_row_fetcher_if bus();

    glyph_row_fetcher dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM contents: digits 1..8 have no blank rows; digit 1 row 5 is special.
    function automatic logic [63:0] rom(input logic [3:0] d, input logic [5:0] y);
        logic [63:0] v;
        if (d == 4'd0 || d > 4'd8)       v = 64'd0;
        else if (d == 4'd1 && y == 6'd5) v = 64'h8000_0000_0000_0001;
        else                             v = {d, {6{y, d}}};
        return v;
    endfunction

    function automatic bit row_skipped(input logic [3:0] d, input logic [5:0] y);
`ifdef BLANK_ROW_SKIP_EN
        return rom(d, y) == 64'd0;
`else
        return 1'b0;
`endif
    endfunction

    always_comb bus.mem_spo = rom(bus.mem_digit, bus.mem_index_y);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int k;
        k = 0;
        while (bus.req_ready !== 1'b1 && k < 10) begin
            step();
            k++;
        end
        chk({tag, ".ready_wait"}, {63'd0, bus.req_ready}, 64'd1);
    endtask

    // One full glyph. stall=1 randomises pix_ready and holds a stray request
    // high throughout, which must be ignored outside IDLE.
    task automatic run_glyph(input logic [3:0] d, input bit stall, input string tag);
        int exp_beats, exp_done, last_row, row_first;
        int beats, dones, done_rel, rel, first_rel, row5_ones;
        logic [5:0] ex, ey;
        logic [63:0] rw;
        bit prev_stall, seen_last;
        logic pd;
        logic [5:0] px, py;

        exp_beats = 0; exp_done = 0; last_row = -1; row_first = -1;
        for (int r = 0; r < 64; r++) begin
            if (!row_skipped(d, 6'(r))) begin
                exp_beats += 64;
                exp_done  += 67;
                last_row   = r;
                if (row_first < 0) row_first = r;
            end else begin
                exp_done += 3;
            end
        end
        exp_done += 1;

        wait_ready(tag);
        bus.req_valid = 1'b1;
        bus.req_digit = d;
        step();
        bus.req_valid = stall;
        bus.req_digit = 4'd9;
        chk({tag, ".mem_digit"}, {60'd0, bus.mem_digit}, {60'd0, d});

        rel = 1; beats = 0; dones = 0; done_rel = 0; first_rel = -1; row5_ones = 0;
        prev_stall = 1'b0; seen_last = 1'b0; pd = 1'b0; px = 6'd0; py = 6'd0;
        ex = 6'd0;
        ey = (row_first < 0) ? 6'd0 : 6'(row_first);

        for (int k = 0; k < 20000 && dones == 0; k++) begin
            bus.pix_ready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            #1;
            if (prev_stall) begin
                chk({tag, ".stall_valid"}, {63'd0, bus.pix_valid}, 64'd1);
                chk({tag, ".stall_data"},  {63'd0, bus.pix_data},  {63'd0, pd});
                chk({tag, ".stall_x"},     {58'd0, bus.pix_x},     {58'd0, px});
                chk({tag, ".stall_y"},     {58'd0, bus.pix_y},     {58'd0, py});
            end
            if (bus.pix_valid === 1'b1) begin
                if (first_rel < 0) first_rel = rel;
                if (bus.pix_ready) begin
                    rw = rom(d, ey);
                    chk({tag, ".x"},    {58'd0, bus.pix_x}, {58'd0, ex});
                    chk({tag, ".y"},    {58'd0, bus.pix_y}, {58'd0, ey});
                    chk({tag, ".data"}, {63'd0, bus.pix_data}, {63'd0, rw[6'd63 - ex]});
                    chk({tag, ".last"}, {63'd0, bus.pix_last},
                        {63'd0, (ex == 6'd63 && int'(ey) == last_row)});
                    chk({tag, ".digit_hold"}, {60'd0, bus.mem_digit}, {60'd0, d});
                    if (bus.pix_last === 1'b1) seen_last = 1'b1;
                    if (bus.pix_y == 6'd5 && bus.pix_data === 1'b1) row5_ones++;
                    beats++;
                    if (ex == 6'd63) begin
                        ex = 6'd0;
                        if (ey != 6'd63) begin
                            ey = ey + 6'd1;
                            while (ey != 6'd63 && row_skipped(d, ey)) ey = ey + 6'd1;
                        end
                    end else begin
                        ex = ex + 6'd1;
                    end
                end
            end
            prev_stall = (bus.pix_valid === 1'b1) && !bus.pix_ready;
            pd = bus.pix_data; px = bus.pix_x; py = bus.pix_y;
            if (bus.done === 1'b1) begin
                dones++;
                done_rel = rel;
                chk({tag, ".ready_in_done"}, {63'd0, bus.req_ready}, 64'd0);
                bus.req_valid = 1'b0;
            end
            step();
            rel++;
        end

        chk({tag, ".done_count"}, 64'(dones), 64'd1);
        chk({tag, ".done_single"}, {63'd0, bus.done}, 64'd0);
        chk({tag, ".beats"}, 64'(beats), 64'(exp_beats));
        chk({tag, ".last_seen"}, {63'd0, seen_last}, {63'd0, exp_beats > 0});
        if (!stall) begin
            chk({tag, ".done_rel"}, 64'(done_rel), 64'(exp_done));
            if (exp_beats > 0) chk({tag, ".first_rel"}, 64'(first_rel), 64'(3 * row_first + 3));
        end
        if (d == 4'd1) chk({tag, ".row5_ones"}, 64'(row5_ones), 64'd2);
        if (d > 4'd8)  chk({tag, ".ones"}, 64'(row5_ones), 64'd0);
    endtask

    task automatic reset_mid_glyph();
        bit found;
        wait_ready("rst");
        bus.req_valid = 1'b1;
        bus.req_digit = 4'd3;
        bus.pix_ready = 1'b1;
        step();
        bus.req_valid = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 3000 && !found; k++) begin
            #1;
            if (bus.pix_valid === 1'b1 && bus.pix_x == 6'd10 && bus.pix_y == 6'd20) found = 1'b1;
            else step();
        end
        chk("rst.reached_r20c10", {63'd0, found}, 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst.pix_valid", {63'd0, bus.pix_valid}, 64'd0);
        chk("rst.req_ready", {63'd0, bus.req_ready}, 64'd1);
        chk("rst.done",      {63'd0, bus.done}, 64'd0);
        chk("rst.mem_digit", {60'd0, bus.mem_digit}, 64'd0);
        step();
        chk("rst.done_after", {63'd0, bus.done}, 64'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_digit = 4'd0;
        bus.pix_ready = 1'b0;
        repeat (3) step();
        rst = 1'b0;

        chk("reset.req_ready",   {63'd0, bus.req_ready}, 64'd1);
        chk("reset.pix_valid",   {63'd0, bus.pix_valid}, 64'd0);
        chk("reset.pix_data",    {63'd0, bus.pix_data},  64'd0);
        chk("reset.pix_x",       {58'd0, bus.pix_x},     64'd0);
        chk("reset.pix_y",       {58'd0, bus.pix_y},     64'd0);
        chk("reset.pix_last",    {63'd0, bus.pix_last},  64'd0);
        chk("reset.done",        {63'd0, bus.done},      64'd0);
        chk("reset.mem_digit",   {60'd0, bus.mem_digit}, 64'd0);
        chk("reset.mem_index_y", {58'd0, bus.mem_index_y}, 64'd0);

        run_glyph(4'd1, 1'b0, "d1");
        run_glyph(4'd2, 1'b1, "stall");
        reset_mid_glyph();
        run_glyph(4'd12, 1'b0, "d12");
        run_glyph(4'd0, 1'b0, "d0");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
